// File: rtl/crono_countdown_ctrl.sv
// Countdown chronometer sequencer: edit, run, pause and expire of an HH:MM:SS countdown.
// Optional alarm auto-clear after ALARM_SECS ticks is built when CRONO_ALARM_TIMEOUT_EN is defined.
module crono_countdown_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_hora,
  input  logic       sw_fecha,
  input  logic       sw_cronometro,
  input  logic       a_cr_hora,
  input  logic       a_cr_min,
  input  logic       a_cr_seg,
  input  logic       inc,
  input  logic       dec,
  input  logic       start_stop,
  input  logic       tick_1hz,
  output logic [4:0] crono_hh,
  output logic [5:0] crono_mm,
  output logic [5:0] crono_ss,
  output logic       running,
  output logic       alarm,
  output logic       edit_en
);

  // state   | meaning
  // IDLE    | mode inactive, time frozen
  // SET     | fields editable with inc/dec
  // RUN     | counting down on tick_1hz
  // PAUSE   | count frozen, waiting for start_stop
  // DONE    | reached 00:00:00, alarm raised
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] hh_q, hh_d;
  logic [5:0] mm_q, mm_d;
  logic [5:0] ss_q, ss_d;
  logic       running_q, alarm_q, edit_en_q;

  logic mode_act;
  logic edit_one;
  logic time_nz;
  logic last_sec;

`ifdef CRONO_ALARM_TIMEOUT_EN
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECS - 1);
  logic [5:0] cnt_q, cnt_d;
`else
  logic alarm_secs_unused;
  assign alarm_secs_unused = ^6'(ALARM_SECS);
`endif

  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] top,
                                            input logic       up);
    if (up) return (v >= top) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign mode_act = sw_cronometro & ~sw_hora & ~sw_fecha;
  assign edit_one = inc ^ dec;
  assign time_nz  = |{hh_q, mm_q, ss_q};
  assign last_sec = (hh_q == 5'd0) && (mm_q == 6'd0) && (ss_q == 6'd1);

  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
`ifdef CRONO_ALARM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (!mode_act) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_SET;
        S_SET: begin
          if (edit_one) begin
            if (a_cr_hora)     hh_d = 5'(step_field({1'b0, hh_q}, 6'd23, inc));
            else if (a_cr_min) mm_d = step_field(mm_q, 6'd59, inc);
            else if (a_cr_seg) ss_d = step_field(ss_q, 6'd59, inc);
          end
          if (start_stop && time_nz) state_d = S_RUN;
        end
        S_RUN: begin
          // start_stop takes priority; a coincident tick is dropped
          if (start_stop) begin
            state_d = S_PAUSE;
          end else if (tick_1hz) begin
            if (ss_q != 6'd0) begin
              ss_d = ss_q - 6'd1;
            end else begin
              ss_d = 6'd59;
              if (mm_q != 6'd0) begin
                mm_d = mm_q - 6'd1;
              end else begin
                mm_d = 6'd59;
                hh_d = hh_q - 5'd1;
              end
            end
            if (last_sec || !time_nz) begin
              hh_d    = 5'd0;
              mm_d    = 6'd0;
              ss_d    = 6'd0;
              state_d = S_DONE;
            end
          end
        end
        S_PAUSE: if (start_stop) state_d = S_RUN;
        S_DONE: begin
          if (start_stop) begin
            state_d = S_SET;
`ifdef CRONO_ALARM_TIMEOUT_EN
          end else if (tick_1hz) begin
            if (cnt_q >= ALARM_LAST) state_d = S_SET;
            else                     cnt_d   = cnt_q + 6'd1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef CRONO_ALARM_TIMEOUT_EN
    // counter is held at zero outside DONE so every entry starts fresh
    if (state_d != S_DONE) cnt_d = 6'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      hh_q      <= 5'd0;
      mm_q      <= 6'd0;
      ss_q      <= 6'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      edit_en_q <= 1'b0;
`ifdef CRONO_ALARM_TIMEOUT_EN
      cnt_q     <= 6'd0;
`endif
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= (state_d == S_DONE);
      edit_en_q <= (state_d == S_SET);
`ifdef CRONO_ALARM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign crono_hh = hh_q;
  assign crono_mm = mm_q;
  assign crono_ss = ss_q;
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign edit_en  = edit_en_q;

endmodule

// File: tb/tb_crono_countdown_ctrl.sv
// Directed bench for crono_countdown_ctrl; expected values are hand-computed per vector.
module tb_crono_countdown_ctrl;

`ifdef CRONO_ALARM_TIMEOUT_EN
  localparam int unsigned ALARM = 3;
`else
  localparam int unsigned ALARM = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_hora, sw_fecha, sw_cronometro;
  logic       a_cr_hora, a_cr_min, a_cr_seg;
  logic       inc, dec, start_stop, tick_1hz;
  logic [4:0] crono_hh;
  logic [5:0] crono_mm, crono_ss;
  logic       running, alarm, edit_en;

  int n_vec = 0;
  int n_err = 0;

  crono_countdown_ctrl #(.ALARM_SECS(ALARM)) dut (
    .clk(clk), .rst(rst),
    .sw_hora(sw_hora), .sw_fecha(sw_fecha), .sw_cronometro(sw_cronometro),
    .a_cr_hora(a_cr_hora), .a_cr_min(a_cr_min), .a_cr_seg(a_cr_seg),
    .inc(inc), .dec(dec), .start_stop(start_stop), .tick_1hz(tick_1hz),
    .crono_hh(crono_hh), .crono_mm(crono_mm), .crono_ss(crono_ss),
    .running(running), .alarm(alarm), .edit_en(edit_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hh"}, 32'(crono_hh), 32'(h));
    check({tag, ".mm"}, 32'(crono_mm), 32'(m));
    check({tag, ".ss"}, 32'(crono_ss), 32'(s));
  endtask

  task automatic check_flags(input string tag, input logic r, input logic a, input logic e);
    check({tag, ".running"}, 32'(running), 32'(r));
    check({tag, ".alarm"},   32'(alarm),   32'(a));
    check({tag, ".edit_en"}, 32'(edit_en), 32'(e));
  endtask

  task automatic pulse_inc(); inc = 1'b1; step(); inc = 1'b0; endtask
  task automatic pulse_dec(); dec = 1'b1; step(); dec = 1'b0; endtask
  task automatic pulse_ss();  start_stop = 1'b1; step(); start_stop = 1'b0; endtask
  task automatic pulse_tick(); tick_1hz = 1'b1; step(); tick_1hz = 1'b0; endtask

  task automatic sel(input logic h, input logic m, input logic s);
    a_cr_hora = h; a_cr_min = m; a_cr_seg = s;
  endtask

  initial begin
    rst = 1'b0;
    sw_hora = 1'b0; sw_fecha = 1'b0; sw_cronometro = 1'b0;
    a_cr_hora = 1'b0; a_cr_min = 1'b0; a_cr_seg = 1'b0;
    inc = 1'b0; dec = 1'b0; start_stop = 1'b0; tick_1hz = 1'b0;
    step(); step();
    check_time("reset", 0, 0, 0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // enter SET and edit minutes, then hours, then hours with seg also selected
    sw_cronometro = 1'b1;
    step();
    check_flags("enter_set", 1'b0, 1'b0, 1'b1);
    sel(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pulse_dec();
    check_time("min_dec3", 0, 57, 0);
    check("min_dec3.edit_en", 32'(edit_en), 32'd1);
    sel(1'b1, 1'b0, 1'b0);
    pulse_inc();
    check_time("hh_inc", 1, 57, 0);
    sel(1'b1, 1'b0, 1'b1);
    pulse_inc();
    check_time("prio_hh", 2, 57, 0);
    inc = 1'b1; dec = 1'b1; step(); inc = 1'b0; dec = 1'b0;
    check_time("inc_dec_both", 2, 57, 0);

    // build 00:01:01
    sel(1'b1, 1'b0, 1'b0);
    pulse_dec(); pulse_dec();
    sel(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pulse_inc();
    check_time("min_wrap_up", 0, 1, 0);
    sel(1'b0, 1'b0, 1'b1);
    pulse_inc();
    sel(1'b0, 1'b0, 1'b0);
    check_time("set_0101", 0, 1, 1);
    pulse_ss();
    check_flags("run", 1'b1, 1'b0, 1'b0);
    pulse_tick();
    check_time("tick1", 0, 1, 0);
    pulse_tick();
    check_time("tick2_borrow", 0, 0, 59);
    for (int i = 0; i < 58; i++) pulse_tick();
    check_time("tick60", 0, 0, 1);
    check("tick60.running", 32'(running), 32'd1);
    pulse_tick();
    check_time("expire", 0, 0, 0);
    check_flags("expire", 1'b0, 1'b1, 1'b0);

`ifdef CRONO_ALARM_TIMEOUT_EN
    pulse_tick(); pulse_tick();
    check("done_t2.alarm", 32'(alarm), 32'd1);
    pulse_tick();
    check_flags("done_timeout", 1'b0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 100; i++) pulse_tick();
    check("done_hold.alarm", 32'(alarm), 32'd1);
    check_time("done_hold", 0, 0, 0);
    pulse_ss();
    check_flags("done_ack", 1'b0, 1'b0, 1'b1);
`endif

    // start at 00:00:00 is ignored; hh wraps downward
    pulse_ss();
    check_flags("start_zero", 1'b0, 1'b0, 1'b1);
    sel(1'b1, 1'b0, 1'b0);
    pulse_dec();
    check_time("hh_wrap_dn", 23, 0, 0);
    pulse_inc();
    check_time("hh_wrap_up", 0, 0, 0);

    // pause: coincident start_stop + tick drops the tick
    sel(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pulse_inc();
    sel(1'b0, 1'b0, 1'b0);
    pulse_ss();
    check("run10.running", 32'(running), 32'd1);
    start_stop = 1'b1; tick_1hz = 1'b1; step(); start_stop = 1'b0; tick_1hz = 1'b0;
    check_time("pause_drop", 0, 0, 10);
    check_flags("pause", 1'b0, 1'b0, 1'b0);
    sel(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pulse_tick();
    pulse_inc();
    sel(1'b0, 1'b0, 1'b0);
    check_time("pause_hold", 0, 0, 10);
    pulse_ss();
    check("resume.running", 32'(running), 32'd1);
    pulse_tick();
    check_time("resume_tick", 0, 0, 9);

    // mode drop in RUN, time held, then re-enter SET
    sw_fecha = 1'b1;
    step();
    check_flags("mode_drop", 1'b0, 1'b0, 1'b0);
    check_time("mode_drop", 0, 0, 9);
    sw_fecha = 1'b0;
    step();
    check("reenter.edit_en", 32'(edit_en), 32'd1);
    sel(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) pulse_dec();
    sel(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) pulse_inc();
    sel(1'b0, 1'b0, 1'b0);
    check_time("set_0500", 0, 5, 0);
    pulse_ss();
    sw_fecha = 1'b1;
    step();
    check_flags("run_drop", 1'b0, 1'b0, 1'b0);
    check_time("run_drop", 0, 5, 0);
    sw_fecha = 1'b0;
    step();
    pulse_ss();
    pulse_tick();
    check_time("borrow_mm", 0, 4, 59);
    check("borrow_mm.running", 32'(running), 32'd1);
    rst = 1'b0;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    check_time("mid_reset", 0, 0, 0);
    check_flags("mid_reset", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
